vol_level_ctrl: RTL

VOL_LEVEL_CTRL -- requirements
Module: vol_level_ctrl

---
 rtl/vol_level_ctrl_pkg.sv | 33 +++
 rtl/vol_level_ctrl_if.sv | 23 ++
 rtl/vol_level_ctrl_peak_hold.sv | 52 +++++
 rtl/vol_level_ctrl.sv | 90 +++++++++
 4 files changed

// File: rtl/vol_level_ctrl_pkg.sv
// Shared constants, types and helpers for the microphone volume-level meter.
// Level geometry: 12-bit unsigned samples, 11-bit amplitude, 4-bit level (0..15).
package vol_level_ctrl_pkg;

  localparam int SAMPLE_W  = 12;
  localparam int AMP_W     = 11;
  localparam int LVL_W     = 4;
  localparam int LVL_MAX   = (1 << LVL_W) - 1;
  localparam int MIC_MID   = 2048;
  localparam int LVL_SHIFT = AMP_W - LVL_W;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [AMP_W-1:0]    amp_t;
  typedef logic [LVL_W-1:0]    level_t;

  typedef enum logic {
    ST_ACCUM,
    ST_UPDATE
  } state_e;

  // Half-wave rectified amplitude; samples below midpoint clamp to 0 instead of wrapping.
  function automatic amp_t amplitude(input sample_t s);
    if (s >= sample_t'(MIC_MID)) begin
      return amp_t'(s - sample_t'(MIC_MID));
    end
    return '0;
  endfunction

  function automatic level_t peak_to_level(input amp_t p);
    return level_t'(p >> LVL_SHIFT);
  endfunction

endpackage

// File: rtl/vol_level_ctrl_if.sv
// Sample stream and level outputs of the volume meter.
// master = sample source / level consumer, slave = the meter itself.
interface vol_level_ctrl_if;
  import vol_level_ctrl_pkg::*;

  logic    sample_valid;
  sample_t mic_in;
  logic    freeze;
  level_t  num;
  level_t  raw_level;
  logic    level_valid;

  modport master (
    output sample_valid, mic_in, freeze,
    input  num, raw_level, level_valid
  );

  modport slave (
    input  sample_valid, mic_in, freeze,
    output num, raw_level, level_valid
  );

endinterface

// File: rtl/vol_level_ctrl_peak_hold.sv
// Displayed-level filter: instant attack, then hold for HOLD_WIN windows
// before decaying one step per window; freeze suspends all changes.
module vol_peak_hold
  import vol_level_ctrl_pkg::*;
#(
  parameter int HOLD_WIN = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  input  level_t raw_level,
  input  logic   update,
  input  logic   freeze,
  output level_t num
);

  localparam int HOLD_W = $clog2(HOLD_WIN) + 1;

  level_t            num_q, num_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    num_d  = num_q;
    hold_d = hold_q;
    if (update && !freeze) begin
      if (raw_level >= num_q) begin
        num_d  = raw_level;
        hold_d = '0;
      end else if (hold_q == HOLD_W'(HOLD_WIN - 1)) begin
        // raw_level < num_q here, so num_q is at least 1 and cannot underflow.
        num_d  = num_q - level_t'(1);
        hold_d = '0;
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q  <= '0;
      hold_q <= '0;
    end else begin
      // NOTE: non-blocking so all registers update from the same pre-edge values.
      num_q  <= num_d;
      hold_q <= hold_d;
    end
  end

  assign num = num_q;

endmodule

// File: rtl/vol_level_ctrl.sv
// Microphone volume meter: per-window peak of the rectified signal, quantised
// to 0..15 and smoothed by vol_peak_hold for the bar display.
module vol_level_ctrl
  import vol_level_ctrl_pkg::*;
#(
  parameter int WINDOW   = 4000,
  parameter int HOLD_WIN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  vol_level_ctrl_if.slave  bus
);

  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  amp_t             peak_q, peak_d;
  level_t           raw_q, raw_d;

  amp_t             amp;
  amp_t             peak_upd;
  logic             window_end;
  logic             level_valid;

  always_comb begin
    amp        = amplitude(bus.mic_in);
    // Count 0 marks the first sample of a window, which replaces the stale peak.
    peak_upd   = ((cnt_q == '0) || (amp > peak_q)) ? amp : peak_q;
    window_end = bus.sample_valid && (cnt_q == CNT_W'(WINDOW - 1));

    state_d     = state_q;
    cnt_d       = cnt_q;
    peak_d      = peak_q;
    raw_d       = raw_q;
    level_valid = 1'b0;

    if (bus.sample_valid) begin
      peak_d = peak_upd;
      cnt_d  = window_end ? '0 : cnt_q + CNT_W'(1);
    end

    // Levels are loaded on the edge entering UPDATE so they are visible during it.
    if (window_end) begin
      raw_d = peak_to_level(peak_upd);
    end

    case (state_q)
      ST_ACCUM: begin
        if (window_end) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        level_valid = 1'b1;
        state_d     = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      cnt_q   <= '0;
      peak_q  <= '0;
      raw_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      peak_q  <= peak_d;
      raw_q   <= raw_d;
    end
  end

  vol_peak_hold #(
    .HOLD_WIN (HOLD_WIN)
  ) u_peak_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_level (raw_d),
    .update    (window_end),
    .freeze    (bus.freeze),
    .num       (bus.num)
  );

  assign bus.raw_level   = raw_q;
  assign bus.level_valid = level_valid;

endmodule
